// File: rtl/fsm_mealy_driver_if.sv
// rtl/fsm_mealy_driver_if.sv - command handshake bundle for the a/b Mealy FSM driver
interface fsm_mealy_driver_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_target;
   logic       done;
   logic       cmd_err;

   // Command source side
   modport master (
      output cmd_valid,
      output cmd_target,
      input  cmd_ready,
      input  done,
      input  cmd_err
   );

   // Driver side
   modport slave (
      input  cmd_valid,
      input  cmd_target,
      output cmd_ready,
      output done,
      output cmd_err
   );
endinterface

// File: rtl/fsm_mealy_driver.sv
// rtl/fsm_mealy_driver.sv - steers the 3-state a/b Mealy FSM to a target state and checks y1/y0
module fsm_mealy_driver #(
   parameter int CNT_W    = 8,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   fsm_mealy_driver_if.slave    cmd,
   output logic                 a_o,
   output logic                 b_o,
   input  logic                 y1_in_i,
   input  logic                 y0_in_i,
   output logic [1:0]           state_o,
   input  logic                 err_clr_i,
   output logic                 err_o,
   output logic [CNT_W-1:0]     err_count_o,
   output logic                 mism_o
);

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;

   typedef enum logic [1:0] {IDLE, STEP1, STEP2, FIN} ctrl_t;

   ctrl_t            ctrl_q, ctrl_d;
   logic             a_q, a_d, b_q, b_d;
   logic [1:0]       state_q, state_d;
   logic [1:0]       st2_q, st2_d;
   logic             two_q, two_d;
   logic             ill_q, ill_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       p_n;
   logic [1:0]       p_st1, p_st2;
   logic             p_ill;
   logic             exp_y1, exp_y0, mism;
   logic             ready_c, done_c, cmd_err_c;

   // Shortest {a,b} step list from the current shadow state to the requested target
   always_comb begin
      p_n   = 2'd0;
      p_st1 = 2'b00;
      p_st2 = 2'b00;
      p_ill = (cmd.cmd_target == 2'b11);
      if (!p_ill && (cmd.cmd_target != state_q)) begin
         case ({state_q, cmd.cmd_target})
            {S0, S1}: begin p_n = 2'd1; p_st1 = 2'b10; end
            {S0, S2}: begin p_n = 2'd1; p_st1 = 2'b11; end
            {S1, S0}: begin p_n = 2'd1; p_st1 = 2'b10; end
            {S2, S0}: begin p_n = 2'd1; p_st1 = 2'b00; end
            {S1, S2}: begin p_n = 2'd2; p_st1 = 2'b10; p_st2 = 2'b11; end
            {S2, S1}: begin p_n = 2'd2; p_st1 = 2'b00; p_st2 = 2'b10; end
            default:  p_n = 2'd0;
         endcase
      end
   end

   // Shadow of the controlled FSM, advanced by the a/b currently being driven
   always_comb begin
      state_d = S0;
      case (state_q)
         S0:      state_d = (a_q && b_q) ? S2 : (a_q ? S1 : S0);
         S1:      state_d = a_q ? S0 : S1;
         default: state_d = S0;
      endcase
   end

   // Compare the returned FSM outputs against what the shadow state predicts
   always_comb begin
      exp_y1 = (state_q == S0) || (state_q == S1);
      exp_y0 = (state_q == S0) && a_q && b_q;
      mism   = CHECK_EN && ((y1_in_i != exp_y1) || (y0_in_i != exp_y0));
   end

   // Sticky error flag and saturating counter; a fresh mismatch beats a clear
   always_comb begin
      err_d = err_q;
      cnt_d = cnt_q;
      if (err_clr_i) begin
         err_d = mism;
         cnt_d = mism ? CNT_W'(1) : '0;
      end else if (mism) begin
         err_d = 1'b1;
         cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // Control FSM next state and command-side outputs
   always_comb begin
      ctrl_d    = ctrl_q;
      a_d       = 1'b0;
      b_d       = 1'b0;
      st2_d     = st2_q;
      two_d     = two_q;
      ill_d     = ill_q;
      ready_c   = 1'b0;
      done_c    = 1'b0;
      cmd_err_c = 1'b0;
      case (ctrl_q)
         IDLE: begin
            ready_c = 1'b1;
            if (cmd.cmd_valid) begin
               st2_d = p_st2;
               two_d = (p_n == 2'd2);
               ill_d = p_ill;
               if (p_n == 2'd0) begin
                  ctrl_d = FIN;
               end else begin
                  {a_d, b_d} = p_st1;
                  ctrl_d     = STEP1;
               end
            end
         end
         STEP1: begin
            if (two_q) begin
               {a_d, b_d} = st2_q;
               ctrl_d     = STEP2;
            end else begin
               ctrl_d = FIN;
            end
         end
         STEP2: ctrl_d = FIN;
         FIN: begin
            done_c    = 1'b1;
            cmd_err_c = ill_q;
            ctrl_d    = IDLE;
         end
         default: ctrl_d = IDLE;
      endcase
   end

   // State registers; reset abandons any command in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= IDLE;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         state_q <= S0;
         st2_q   <= 2'b00;
         two_q   <= 1'b0;
         ill_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         state_q <= state_d;
         st2_q   <= st2_d;
         two_q   <= two_d;
         ill_q   <= ill_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cmd.cmd_ready = ready_c;
   assign cmd.done      = done_c;
   assign cmd.cmd_err   = cmd_err_c;
   assign a_o           = a_q;
   assign b_o           = b_q;
   assign state_o       = state_q;
   assign err_o         = err_q;
   assign err_count_o   = cnt_q;
   assign mism_o        = mism;

endmodule

// File: tb/tb_fsm_mealy_driver.sv
// tb/tb_fsm_mealy_driver.sv - scoreboard bench for fsm_mealy_driver with a behavioural plant FSM
module tb_fsm_mealy_driver;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a, b, y1, y0, err_clr, err, mism;
   logic [1:0] st;
   logic [7:0] ecnt;
   logic [1:0] plant;
   bit         force_y1 = 1'b0;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         mcnt = 0;
   bit         merr = 1'b0;

   typedef struct {
      int         k;
      int         n;
      bit         ill;
      logic [1:0] tgt;
      logic [1:0] s_start;
      logic [1:0] st1;
      logic [1:0] st2;
   } rec_t;
   rec_t q[$];

   fsm_mealy_driver_if cmd();

   fsm_mealy_driver #(.CNT_W(8), .CHECK_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .cmd(cmd),
      .a_o(a), .b_o(b), .y1_in_i(y1), .y0_in_i(y0),
      .state_o(st), .err_clr_i(err_clr), .err_o(err),
      .err_count_o(ecnt), .mism_o(mism)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] nxt(logic [1:0] s, logic [1:0] ab);
      if (s == 2'd0) return (ab == 2'b11) ? 2'd2 : (ab[1] ? 2'd1 : 2'd0);
      if (s == 2'd1) return ab[1] ? 2'd0 : 2'd1;
      return 2'd0;
   endfunction

   // The controlled FSM, modelled from its transition rules
   always @(posedge clk or posedge rst) begin
      if (rst) plant <= 2'd0;
      else     plant <= nxt(plant, {a, b});
   end
   assign y1 = ((plant == 2'd0) || (plant == 2'd1)) && !force_y1;
   assign y0 = (plant == 2'd0) && a && b;

   // Breadth-first search for the shortest drive sequence, trying 00, 10, 11 in that order
   function automatic rec_t plan(logic [1:0] s, logic [1:0] t, int k);
      rec_t r;
      logic [1:0] cand [3];
      bit found = 1'b0;
      cand = '{2'b00, 2'b10, 2'b11};
      r.k = k; r.n = 0; r.ill = (t == 2'b11); r.tgt = t; r.s_start = s;
      r.st1 = 2'b00; r.st2 = 2'b00;
      if (!r.ill && t != s) begin
         for (int i = 0; i < 3; i++)
            if (!found && nxt(s, cand[i]) == t) begin
               r.n = 1; r.st1 = cand[i]; found = 1'b1;
            end
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               if (!found && nxt(nxt(s, cand[i]), cand[j]) == t) begin
                  r.n = 2; r.st1 = cand[i]; r.st2 = cand[j]; found = 1'b1;
               end
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares every cycle against the head of the scoreboard queue
   always @(negedge clk) begin
      logic [1:0] exp_ab;
      bit exp_done, exp_ready, exp_cerr, exp_mism;
      int off;
      if (rst) begin
         mcnt = 0;
         merr = 1'b0;
      end else begin
         exp_ab = 2'b00; exp_done = 1'b0; exp_ready = 1'b1; exp_cerr = 1'b0;
         if (q.size() > 0) begin
            off = cyc - q[0].k;
            if (off >= 0) begin
               exp_ready = 1'b0;
               if (off == 0 && q[0].n >= 1) exp_ab = q[0].st1;
               if (off == 1 && q[0].n == 2) exp_ab = q[0].st2;
               if (off == q[0].n) begin
                  exp_done = 1'b1;
                  exp_cerr = q[0].ill;
               end
            end
         end
         chk("ab", {30'd0, a, b}, {30'd0, exp_ab});
         chk("done", {31'd0, cmd.done}, {31'd0, exp_done});
         chk("cmd_err", {31'd0, cmd.cmd_err}, {31'd0, exp_cerr});
         chk("cmd_ready", {31'd0, cmd.cmd_ready}, {31'd0, exp_ready});
         chk("state_o", {30'd0, st}, {30'd0, plant});
         if (exp_done) begin
            chk("reached", {30'd0, plant}, {30'd0, q[0].ill ? q[0].s_start : q[0].tgt});
            void'(q.pop_front());
         end
         exp_mism = force_y1 && (plant != 2'd2);
         chk("mism", {31'd0, mism}, {31'd0, exp_mism});
         chk("err", {31'd0, err}, {31'd0, merr});
         chk("err_count", {24'd0, ecnt}, mcnt);
         if (err_clr) begin
            merr = exp_mism;
            mcnt = exp_mism ? 1 : 0;
         end else if (exp_mism) begin
            merr = 1'b1;
            mcnt = (mcnt == 255) ? 255 : mcnt + 1;
         end
      end
   end

   task automatic tick(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Hold valid until the driver is ready; the record is pushed for the accepting edge
   task automatic send(logic [1:0] t);
      bit ok = 1'b0;
      cmd.cmd_valid  = 1'b1;
      cmd.cmd_target = t;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (cmd.cmd_ready) begin
            q.push_back(plan(plant, t, cyc + 1));
            ok = 1'b1;
         end
         tick(1);
      end
      cmd.cmd_valid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1 at t=%0t", $time);
      end
   endtask

   task automatic drain();
      int i = 0;
      while (q.size() > 0 && i < 40) begin
         tick(1);
         i++;
      end
      if (q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout: got pending=%0d expected pending=0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      cmd.cmd_valid = 1'b0; cmd.cmd_target = 2'b00; err_clr = 1'b0;
      tick(2);
      chk("rst_ab", {30'd0, a, b}, 0);
      chk("rst_state", {30'd0, st}, 0);
      chk("rst_ready", {31'd0, cmd.cmd_ready}, 1);
      chk("rst_done", {31'd0, cmd.done}, 0);
      chk("rst_err", {31'd0, err}, 0);
      rst = 1'b0;
      tick(2);

      send(2'd2); drain(); tick(1);
      send(2'd1); drain();
      send(2'd2); drain(); tick(1);
      send(2'd3); drain();

      for (int n = 0; n < 40; n++) begin
         send(2'($urandom_range(0, 3)));
         tick($urandom_range(0, 2));
      end
      drain();
      tick(2);

      force_y1 = 1'b1;
      tick(300);
      chk("sat_err", {31'd0, err}, 1);
      chk("sat_count", {24'd0, ecnt}, 255);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      force_y1 = 1'b0;
      chk("clr_mism_count", {24'd0, ecnt}, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("clr_count", {24'd0, ecnt}, 0);
      chk("clr_err", {31'd0, err}, 0);

      send(2'd0); drain();
      send(2'd1); drain(); tick(1);
      send(2'd2);
      tick(1);
      chk("step2_ab", {30'd0, a, b}, 3);
      rst = 1'b1;
      #1;
      q.delete();
      chk("mid_rst_ab", {30'd0, a, b}, 0);
      chk("mid_rst_state", {30'd0, st}, 0);
      chk("mid_rst_ready", {31'd0, cmd.cmd_ready}, 1);
      chk("mid_rst_done", {31'd0, cmd.done}, 0);
      tick(2);
      rst = 1'b0;
      tick(6);
      send(2'd1); drain(); tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
